// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state encoding, datapath widths and the default reset PC.
package instruction_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_buffer.sv
// One-entry instruction register between fetch and decode.
// Ports: clk, rst (async high); i_load/i_ir/i_pc write a new word,
// i_flush kills the entry, i_ready consumes it; o_ir/o_pc/o_valid present it.
module fetch_buffer
    import instruction_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [INSTR_W-1:0] i_ir,
    input  logic [ADDR_W-1:0]  i_pc,
    input  logic               i_flush,
    input  logic               i_ready,
    output logic [INSTR_W-1:0] o_ir,
    output logic [ADDR_W-1:0]  o_pc,
    output logic               o_valid
);

    logic [INSTR_W-1:0] r_ir;
    logic [ADDR_W-1:0]  r_pc;
    logic               r_valid;

    // Flush beats load beats transfer; data/pc hold on flush and transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir    <= '0;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_ir    <= i_ir;
            r_pc    <= i_pc;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_ir    = r_ir;
    assign o_pc    = r_pc;
    assign o_valid = r_valid;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC register, single-outstanding memory FSM, redirect flush.
// Ports: clk, rst; imem_req_o/addr_o/ack_i/rvalid_i/rdata_i memory side;
// ir_o/pc_o/ir_valid_o/ir_ready_i decode side; redirect_i/redirect_pc_i.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_ack_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic [INSTR_W-1:0] ir_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic               ir_valid_o,
    input  logic               ir_ready_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i
);

    localparam logic [ADDR_W-1:0] RESET_PC_AL = {RESET_PC[ADDR_W-1:2], 2'b00};

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_pend_pc;

    logic w_ir_valid;
    logic w_hs;
    logic w_load;

    // Only issue when the buffer will have room for the returning word.
    assign imem_req_o  = (r_state == FETCH) && (!w_ir_valid || ir_ready_i)
                         && !redirect_i;
    assign imem_addr_o = r_fetch_pc;
    assign w_hs        = imem_req_o && imem_ack_i;
    assign w_load      = (r_state == WAIT) && imem_rvalid_i && !redirect_i;
    assign ir_valid_o  = w_ir_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= FETCH;
            r_fetch_pc <= RESET_PC_AL;
            r_pend_pc  <= '0;
        end else if (redirect_i) begin
            r_fetch_pc <= {redirect_pc_i[ADDR_W-1:2], 2'b00};
            // A request already accepted by memory must still be drained.
            case (r_state)
                FETCH:   r_state <= imem_ack_i ? DROP : FETCH;
                WAIT:    r_state <= imem_rvalid_i ? FETCH : DROP;
                DROP:    r_state <= imem_rvalid_i ? FETCH : DROP;
                default: r_state <= FETCH;
            endcase
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_hs) begin
                        r_pend_pc  <= r_fetch_pc;
                        r_fetch_pc <= r_fetch_pc + 32'd4;
                        r_state    <= WAIT;
                    end
                end
                WAIT:    if (imem_rvalid_i) r_state <= FETCH;
                DROP:    if (imem_rvalid_i) r_state <= FETCH;
                default: r_state <= FETCH;
            endcase
        end
    end

    fetch_buffer u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_ir    (imem_rdata_i),
        .i_pc    (r_pend_pc),
        .i_flush (redirect_i),
        .i_ready (ir_ready_i),
        .o_ir    (ir_o),
        .o_pc    (pc_o),
        .o_valid (w_ir_valid)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed cycle-by-cycle vectors for the instruction fetch unit.
// Each vector drives one cycle of inputs and checks that cycle's outputs.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] ir_o;
    logic [31:0] pc_o;
    logic        ir_valid_o;
    logic        ir_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ack;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ir;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vq[$];

    instruction_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .ir_o          (ir_o),
        .pc_o          (pc_o),
        .ir_valid_o    (ir_valid_o),
        .ir_ready_i    (ir_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, want %08h", nm, got, exp);
        end
    endtask

    task automatic add(input logic ack, input logic rv, input logic [31:0] rd,
                       input logic rdy, input logic rdr, input logic [31:0] rpc,
                       input logic eq, input logic [31:0] ea, input logic ev,
                       input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v.ack = ack; v.rvalid = rv; v.rdata = rd; v.ready = rdy;
        v.redir = rdr; v.rpc = rpc;
        v.e_req = eq; v.e_addr = ea; v.e_valid = ev;
        v.e_ir = ei; v.e_pc = ep;
        vq.push_back(v);
    endtask

    task automatic drive(input logic ack, input logic rv, input logic [31:0] rd,
                         input logic rdy, input logic rdr,
                         input logic [31:0] rpc);
        imem_ack_i    = ack;
        imem_rvalid_i = rv;
        imem_rdata_i  = rd;
        ir_ready_i    = rdy;
        redirect_i    = rdr;
        redirect_pc_i = rpc;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);

        // ack rv rdata rdy rdr rpc | req addr valid ir pc
        // basic fetch and 2-cycle throughput
        add(1,0,32'h0,       1,0,0, 1,32'h0,  0,32'h0,       32'h0);
        add(0,1,32'h04000001,1,0,0, 0,32'h4,  0,32'h0,       32'h0);
        add(1,0,32'h0,       1,0,0, 1,32'h4,  1,32'h04000001,32'h0);
        add(0,1,32'h00A00093,1,0,0, 0,32'h8,  0,32'h04000001,32'h0);
        // decode stalls for 5 cycles
        for (int i = 0; i < 5; i++)
            add(1,0,32'h0,   0,0,0, 0,32'h8,  1,32'h00A00093,32'h4);
        add(1,0,32'h0,       1,0,0, 1,32'h8,  1,32'h00A00093,32'h4);
        // redirect while pc 8 outstanding, rvalid 3 cycles later
        add(0,0,32'h0,       1,1,32'h43, 0,32'hC,  0,32'h00A00093,32'h4);
        add(1,0,32'h0,       1,0,0, 0,32'h40, 0,32'h00A00093,32'h4);
        add(1,0,32'h0,       1,0,0, 0,32'h40, 0,32'h00A00093,32'h4);
        add(0,1,32'hDEADBEEF,1,0,0, 0,32'h40, 0,32'h00A00093,32'h4);
        add(1,0,32'h0,       1,0,0, 1,32'h40, 0,32'h00A00093,32'h4);
        add(0,1,32'h11111111,1,0,0, 0,32'h44, 0,32'h00A00093,32'h4);
        // redirect coincident with ack in FETCH
        add(1,0,32'h0,       1,1,32'h200, 0,32'h44, 1,32'h11111111,32'h40);
        add(0,1,32'hCAFEBABE,1,0,0, 0,32'h200,0,32'h11111111,32'h40);
        add(1,0,32'h0,       1,0,0, 1,32'h200,0,32'h11111111,32'h40);
        add(0,1,32'h22222222,1,0,0, 0,32'h204,0,32'h11111111,32'h40);
        // redirect to top of address space, low bits forced to 0
        add(0,0,32'h0,       0,1,32'hFFFFFFFF, 0,32'h204,1,32'h22222222,32'h200);
        add(1,0,32'h0,       1,0,0, 1,32'hFFFFFFFC,0,32'h22222222,32'h200);
        add(0,1,32'h33333333,1,0,0, 0,32'h0,  0,32'h22222222,32'h200);
        add(1,0,32'h0,       1,0,0, 1,32'h0,  1,32'h33333333,32'hFFFFFFFC);
        add(0,1,32'h44444444,1,0,0, 0,32'h4,  0,32'h33333333,32'hFFFFFFFC);
        // stray rvalid in FETCH is ignored
        add(0,1,32'h55555555,0,0,0, 0,32'h4,  1,32'h44444444,32'h0);
        add(0,0,32'h0,       0,0,0, 0,32'h4,  1,32'h44444444,32'h0);
        // memory wait state: request held without ack
        add(0,0,32'h0,       1,0,0, 1,32'h4,  1,32'h44444444,32'h0);
        add(1,0,32'h0,       1,0,0, 1,32'h4,  0,32'h44444444,32'h0);

        repeat (2) @(negedge clk);
        #1;
        chk("rst_addr",  imem_addr_o, 32'h0);
        chk("rst_valid", {31'b0, ir_valid_o}, 32'h0);
        chk("rst_ir",    ir_o, 32'h0);
        chk("rst_pc",    pc_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[k]) begin
            drive(vq[k].ack, vq[k].rvalid, vq[k].rdata,
                  vq[k].ready, vq[k].redir, vq[k].rpc);
            #1;
            chk($sformatf("v%0d_req", k),   {31'b0, imem_req_o}, {31'b0, vq[k].e_req});
            chk($sformatf("v%0d_addr", k),  imem_addr_o, vq[k].e_addr);
            chk($sformatf("v%0d_valid", k), {31'b0, ir_valid_o}, {31'b0, vq[k].e_valid});
            chk($sformatf("v%0d_ir", k),    ir_o, vq[k].e_ir);
            chk($sformatf("v%0d_pc", k),    pc_o, vq[k].e_pc);
            @(negedge clk);
        end

        // reset asserted mid-WAIT (pc 4 outstanding), stray rvalid afterwards
        drive(0, 0, 0, 1, 0, 0);
        #1;
        chk("mw_req", {31'b0, imem_req_o}, 32'h0);
        chk("mw_addr", imem_addr_o, 32'h8);
        rst = 1'b1;
        #1;
        chk("ar_addr",  imem_addr_o, 32'h0);
        chk("ar_valid", {31'b0, ir_valid_o}, 32'h0);
        chk("ar_ir",    ir_o, 32'h0);
        chk("ar_pc",    pc_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1, 32'h66666666, 1, 0, 0);
        #1;
        chk("pr_req",  {31'b0, imem_req_o}, 32'h1);
        chk("pr_addr", imem_addr_o, 32'h0);
        @(negedge clk);
        drive(1, 0, 0, 1, 0, 0);
        #1;
        chk("pr2_req",   {31'b0, imem_req_o}, 32'h1);
        chk("pr2_addr",  imem_addr_o, 32'h0);
        chk("pr2_valid", {31'b0, ir_valid_o}, 32'h0);
        chk("pr2_ir",    ir_o, 32'h0);
        @(negedge clk);
        drive(0, 1, 32'h77777777, 1, 0, 0);
        #1;
        chk("pr3_req",  {31'b0, imem_req_o}, 32'h0);
        chk("pr3_addr", imem_addr_o, 32'h4);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("pr4_valid", {31'b0, ir_valid_o}, 32'h1);
        chk("pr4_ir",    ir_o, 32'h77777777);
        chk("pr4_pc",    pc_o, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 imem_req_o  output  1  instruction memory read request.
REQ-005 imem_addr_o  output  32  byte address of request, bits [1:0] always 0.
REQ-006 imem_ack_i  input  1  memory accepts request this cycle (req & ack = handshake).
REQ-007 imem_rvalid_i  input  1  read data valid; exactly one per accepted request, at least 1 cycle after ack.
REQ-008 imem_rdata_i  input  32  instruction word.
REQ-009 ir_o  output  32  instruction presented to control unit / decode.
REQ-010 pc_o  output  32  address from which ir_o was fetched.
REQ-011 ir_valid_o  output  1  ir_o/pc_o valid.
REQ-012 ir_ready_i  input  1  decode consumes ir_o (valid & ready = transfer).
REQ-013 redirect_i  input  1  branch/jump taken (beq, bne, blt, ble, j, jal, jr); flush and refetch.
REQ-014 redirect_pc_i  input  32  new fetch address; bits [1:0] ignored, forced to 0.

Function
REQ-015 FSM states SHALL be FETCH, WAIT, DROP; at most one outstanding memory request at any time.
REQ-016 imem_req_o SHALL equal (state==FETCH) & (!ir_valid_o | ir_ready_i) & !redirect_i; imem_addr_o SHALL equal the fetch PC register.
REQ-017 FETCH, handshake, no redirect: latch request address as pending PC, fetch PC += 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), go WAIT.
REQ-018 WAIT, imem_rvalid_i, no redirect: ir_o <= imem_rdata_i, pc_o <= pending PC, ir_valid_o <= 1, go FETCH; word visible the cycle after rvalid (1-cycle latency).
REQ-019 ir_valid_o SHALL stay high with ir_o/pc_o stable until ir_ready_i; on transfer without new load, ir_valid_o <= 0.
REQ-020 redirect_i in any state: fetch PC <= {redirect_pc_i[31:2],2'b00}, ir_valid_o <= 0 next cycle; redirect has priority over load and transfer.
REQ-021 redirect_i in WAIT without rvalid: go DROP; with rvalid same cycle: discard data, go FETCH.
REQ-022 redirect_i in FETCH while imem_ack_i high: acknowledged stale request SHALL be treated as outstanding; go DROP.
REQ-023 DROP: on imem_rvalid_i discard data, go FETCH; redirect_i in DROP updates fetch PC only, stays DROP.
REQ-024 Discarded data SHALL never appear on ir_o or raise ir_valid_o.
REQ-025 imem_rvalid_i in FETCH SHALL be ignored (protocol violation, no state change).
REQ-026 Steady state with zero-wait memory (ack same cycle, rvalid next) and ready held high: one instruction every 2 cycles.

Reset
REQ-027 rst asserted SHALL immediately set state FETCH, fetch PC RESET_PC, ir_valid_o 0, ir_o 0, pc_o 0.
REQ-028 rst mid-WAIT SHALL drop the pending transaction; its later rvalid (if any) arrives in FETCH and is ignored per REQ-025.
REQ-029 First request SHALL be raised in the first cycle after rst deasserts.

Structure
REQ-030 Shared package SHALL hold the FSM state enum, INSTR_W=32, ADDR_W=32, RESET_PC default.
REQ-031 The one-entry output register (ir_o, pc_o, ir_valid_o, load/transfer/flush) SHALL be a sub-module fetch_buffer; FSM and PC remain in instruction_fetch.

Verification
REQ-032 Reset release, memory acks immediately, rdata=32'h0400_0001 (addi) -> imem_addr_o 0, then ir_o=32'h0400_0001, pc_o=0, ir_valid_o=1; next request addr 4.
REQ-033 ir_ready_i held 0 for 5 cycles with ir_valid_o=1 -> imem_req_o stays 0, ir_o stable; ready=1 -> request for next PC same cycle.
REQ-034 redirect_i in WAIT (pc 8 outstanding), redirect_pc_i=32'h0000_0043, rvalid 3 cycles later -> data discarded, next request addr 32'h40, ir_valid_o never set for pc 8.
REQ-035 redirect_i coincident with imem_ack_i in FETCH -> DROP; following rvalid discarded; subsequent request at redirect target.
REQ-036 redirect_pc_i=32'hFFFF_FFFC, sequential fetches -> addresses FFFF_FFFC then 0000_0000.
REQ-037 rst asserted during WAIT, rvalid after release -> outputs 0, first request at RESET_PC, stray rvalid ignored.
